// File: rtl/neg_unit_pkg.sv
// Shared types and constants for the shared NOT/NEG unit.
// Imported by the arbiter top and its round-robin picker.
package neg_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } neg_state_e;

    localparam logic OP_NOT = 1'b0;
    localparam logic OP_NEG = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid at or after rr_ptr.
// The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    logic [ID_W-1:0] idx;
    logic            found;

    // Scan from the pointer with wrap; the first valid requester wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        idx         = '0;
        found       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (!found && valid_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/neg_unit_arbiter.sv
// Round-robin front end for the shared WIDTH-bit NOT/NEG unit.
// One operand in flight; result returned on a valid/ready port.
module neg_unit_arbiter
    import neg_unit_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int WIDTH   = 64,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic                     busy
);

    neg_state_e      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [ID_W-1:0] gnt_idx;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [WIDTH-1:0] sel_data, opnd_inv;
    logic             op_q, op_d, sel_op, accept;
    logic [NUM_REQ-1:0] grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid_i     (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (gnt_idx)
    );

    // Route the granted requester's operand and op to the latch inputs.
    always_comb begin
        sel_data = '0;
        sel_op   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
                sel_op   = req_op[i];
            end
        end
    end

    assign opnd_inv = ~opnd_q;

    // Next state: accept in IDLE or on a RESP handshake, compute in EXEC.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        opnd_d      = opnd_q;
        op_d        = op_q;
        id_d        = id_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: accept = |req_valid;
            EXEC: begin
                unique case (op_q)
                    OP_NOT: resp_data_d = opnd_inv;
                    OP_NEG: resp_data_d = opnd_inv + WIDTH'(1);
                endcase
                resp_id_d = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    accept  = |req_valid;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d  = EXEC;
            opnd_d   = sel_data;
            op_d     = sel_op;
            id_d     = gnt_idx;
            rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0
                                                       : gnt_idx + ID_W'(1);
        end
    end

    // State registers; reset drops any latched operand or pending result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            opnd_q      <= '0;
            op_q        <= 1'b0;
            id_q        <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            opnd_q      <= opnd_d;
            op_q        <= op_d;
            id_q        <= id_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign req_ready  = (accept && reset) ? grant : '0;
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_neg_unit_arbiter.sv
// Directed-vector and random bench for neg_unit_arbiter.
// Expected results come from hand values and a small reference model.
module tb_neg_unit_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_op;
    logic [127:0] req_data;
    logic [1:0]   req_ready;
    logic         resp_valid;
    logic         resp_ready;
    logic [63:0]  resp_data;
    logic [0:0]   resp_id;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int tb_ptr = 0;

    always #5 clk = ~clk;

    neg_unit_arbiter #(.NUM_REQ(2), .WIDTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  op;
        logic [63:0] d0;
        logic [63:0] d1;
        int          eid;
        logic [63:0] edata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after a posedge, with resp_ready=1.
    task automatic txn(input logic [1:0] v, input logic [1:0] op,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input int eid, input logic [63:0] edata);
        int n;
        req_valid = v;
        req_op    = op;
        req_data  = {d1, d0};
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 20) begin
            step();
            n++;
        end
        chk("accept_timeout", 64'(n < 20), 64'd1);
        chk("grant_onehot", 64'(req_ready), 64'(2'b01 << eid));
        step();
        req_valid = 2'b00;
        chk("lat_exec_low", 64'(resp_valid), 64'd0);
        step();
        chk("lat_resp_high", 64'(resp_valid), 64'd1);
        chk("resp_id", 64'(resp_id), 64'(eid));
        chk("resp_data", resp_data, edata);
        step();
        chk("idle_after", 64'(busy), 64'd0);
        tb_ptr = (eid + 1) % 2;
    endtask

    initial begin
        int ids[$];
        int n, last, gap;
        logic [63:0] hold_d;
        logic [0:0]  hold_id;

        vecs[0] = '{2'b01, 2'b00, 64'hFF, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FF00};
        vecs[1] = '{2'b10, 2'b10, 64'h0, 64'h1, 1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{2'b10, 2'b10, 64'h0, 64'h0, 1, 64'h0};
        vecs[3] = '{2'b10, 2'b10, 64'h0, 64'h8000_0000_0000_0000, 1,
                    64'h8000_0000_0000_0000};
        vecs[4] = '{2'b01, 2'b01, 64'h5, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFB};
        vecs[5] = '{2'b11, 2'b10, 64'h1234, 64'h10, 1, 64'hFFFF_FFFF_FFFF_FFF0};
        vecs[6] = '{2'b11, 2'b10, 64'h1234, 64'h10, 0, 64'hFFFF_FFFF_FFFF_EDCB};
        vecs[7] = '{2'b01, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 64'h0};

        reset      = 1'b0;
        req_valid  = 2'b11;
        req_op     = 2'b00;
        req_data   = '0;
        resp_ready = 1'b1;

        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_valid", 64'(resp_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end
        req_valid = 2'b00;
        reset     = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            txn(vecs[i].v, vecs[i].op, vecs[i].d0, vecs[i].d1,
                vecs[i].eid, vecs[i].edata);

        // Both requesters always valid: grants alternate from ptr=1.
        req_valid = 2'b11;
        req_op    = 2'b00;
        req_data  = {64'hB, 64'hA};
        n = 0;
        last = -1;
        while (ids.size() < 4 && n < 40) begin
            step();
            n++;
            if (resp_valid) begin
                ids.push_back(int'(resp_id));
                chk("alt_data", resp_data,
                    resp_id ? 64'hFFFF_FFFF_FFFF_FFF4 : 64'hFFFF_FFFF_FFFF_FFF5);
                if (last >= 0) begin
                    gap = n - last;
                    chk("alt_period", 64'(gap), 64'd2);
                end
                last = n;
                if (ids.size() == 4) req_valid = 2'b00;
            end
        end
        chk("alt_count", 64'(ids.size()), 64'd4);
        for (int i = 0; i < ids.size(); i++)
            chk("alt_order", 64'(ids[i]), 64'((i + 1) % 2));
        step();
        chk("alt_drain", 64'(busy), 64'd0);

        // Backpressure: hold RESP for 5 cycles with a waiting requester.
        resp_ready = 1'b0;
        req_valid  = 2'b10;
        req_op     = 2'b10;
        req_data   = {64'h3, 64'h7};
        #1;
        chk("bp_grant", 64'(req_ready), 64'b10);
        step();
        req_valid = 2'b00;
        step();
        chk("bp_resp", 64'(resp_valid), 64'd1);
        chk("bp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFD);
        hold_d  = resp_data;
        hold_id = resp_id;
        req_valid = 2'b01;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_noready", 64'(req_ready), 64'd0);
            step();
            chk("bp_hold_data", resp_data, hold_d);
            chk("bp_hold_id", 64'(resp_id), 64'(hold_id));
            chk("bp_hold_valid", 64'(resp_valid), 64'd1);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 64'(req_ready), 64'b01);
        step();
        req_valid = 2'b00;
        chk("bp_exec", 64'(resp_valid), 64'd0);
        step();
        chk("bp_next_id", 64'(resp_id), 64'd0);
        chk("bp_next_data", resp_data, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        tb_ptr = 1;

        // Reset while EXEC: no response, pointer back to 0.
        req_valid = 2'b01;
        req_op    = 2'b00;
        req_data  = {64'h0, 64'h55};
        #1;
        chk("re_grant", 64'(req_ready), 64'b01);
        step();
        req_valid = 2'b00;
        chk("re_in_exec", 64'(busy), 64'd1);
        reset = 1'b0;
        step();
        chk("re_idle", 64'(busy), 64'd0);
        chk("re_no_resp", 64'(resp_valid), 64'd0);
        reset = 1'b1;
        step();
        chk("re_no_resp2", 64'(resp_valid), 64'd0);
        chk("re_data_clr", resp_data, 64'd0);
        req_valid = 2'b11;
        #1;
        chk("re_ptr0", 64'(req_ready), 64'b01);
        req_valid = 2'b00;
        step();
        tb_ptr = 0;

        // Random mixed ops against a reference model.
        for (int t = 0; t < 1000; t++) begin
            logic [1:0]  v, op;
            logic [63:0] d0, d1, x;
            int          w;
            v  = 2'($urandom_range(1, 3));
            op = 2'($urandom_range(0, 3));
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            if (t % 50 == 0) d0 = 64'h8000_0000_0000_0000;
            if (t % 50 == 1) d1 = 64'h0;
            w = v[tb_ptr] ? tb_ptr : 1 - tb_ptr;
            x = (w == 0) ? d0 : d1;
            txn(v, op, d0, d1, w, op[w] ? (64'd0 - x) : ~x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
